// File: rtl/npu_pkg.sv
// Shared definitions for the NPU host-side feeder and the NPU word bus:
// sequencer state encoding, load-frame geometry and default field widths.
package npu_pkg;

    localparam int NPU_DW     = 32;
    localparam int NPU_NCNT_W = 5;
    localparam int NPU_WCNT_W = 12;

    localparam int CFG_WORDS   = 6;
    localparam int LEAD_CYCLES = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_CFG,
        ST_WGT,
        ST_INP,
        ST_CALC,
        ST_OUT,
        ST_FIN
    } feeder_state_t;

endpackage

// File: rtl/npu_host_feeder_if.sv
// Shared NPU word bus (we/oe plus split tri-state data) between the host
// feeder (master) and the NPU-side bus attachment (slave).
interface npu_host_feeder_if
    import npu_pkg::*;
#(
    parameter int DW = NPU_DW
);

    logic          npu_we;
    logic          npu_oe;
    logic [DW-1:0] npu_data_out;
    logic          npu_data_drv;
    logic [DW-1:0] npu_data_in;

    modport master (
        output npu_we,
        output npu_oe,
        output npu_data_out,
        output npu_data_drv,
        input  npu_data_in
    );

    modport slave (
        input  npu_we,
        input  npu_oe,
        input  npu_data_out,
        input  npu_data_drv,
        output npu_data_in
    );

endinterface

// File: rtl/npu_result_capture.sv
// Captures the NPU output neurons during oe cycles and turns them into a
// result stream, flagging the final neuron of each data set.
module npu_result_capture
    import npu_pkg::*;
#(
    parameter int DW     = NPU_DW,
    parameter int NCNT_W = NPU_NCNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_oe,
    input  logic [NCNT_W-1:0] i_num_out,
    input  logic [DW-1:0]     i_data_in,
    output logic [DW-1:0]     o_res_data,
    output logic              o_res_valid,
    output logic              o_res_last
);

    logic [NCNT_W-1:0] r_ocnt;
    logic [DW-1:0]     r_res_data;
    logic              r_res_valid;
    logic              r_res_last;
    logic              w_last;

    assign w_last = (r_ocnt == i_num_out);

    // i_oe is the registered bus oe, so sampling here is the end of the oe cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ocnt      <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_res_last  <= 1'b0;
        end else begin
            r_res_valid <= i_oe;
            r_res_last  <= i_oe && w_last;
            if (i_oe) begin
                r_res_data <= i_data_in;
            end
            if (i_clear) begin
                r_ocnt <= '0;
            end else if (i_oe) begin
                r_ocnt <= w_last ? '0 : r_ocnt + NCNT_W'(1);
            end
        end
    end

    assign o_res_data  = r_res_data;
    assign o_res_valid = r_res_valid;
    assign o_res_last  = r_res_last;

endmodule

// File: rtl/npu_host_feeder.sv
// Host-side sequencer for the NPU word bus: per data set drives lead, config,
// weight and input words, waits the calculation time, then reads the outputs.
module npu_host_feeder
    import npu_pkg::*;
#(
    parameter int DW     = NPU_DW,
    parameter int WCNT_W = NPU_WCNT_W,
    parameter int NCNT_W = NPU_NCNT_W,
    parameter int SET_W  = 17,
    parameter int CALC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         cfg_num_layers,
    input  logic [NCNT_W-1:0]  cfg_num_in,
    input  logic [NCNT_W-1:0]  cfg_num_h1,
    input  logic [NCNT_W-1:0]  cfg_num_h2,
    input  logic [NCNT_W-1:0]  cfg_num_out,
    input  logic [1:0]         cfg_act,
    input  logic [WCNT_W-1:0]  cfg_num_w,
    input  logic [CALC_W-1:0]  cfg_calc_cycles,
    input  logic [SET_W-1:0]   cfg_num_sets,
    input  logic [DW-1:0]      src_data,
    input  logic               src_valid,
    output logic               src_ready,
    npu_host_feeder_if.master  bus,
    output logic [DW-1:0]      res_data,
    output logic               res_valid,
    output logic               res_last,
    output logic               busy,
    output logic               done,
    output logic               err_underrun
);

    localparam int CNT_W = WCNT_W + 1;
    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_LEAD_LAST = CNT_W'(LEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CFG_LAST  = CNT_W'(CFG_WORDS - 1);

    feeder_state_t     r_state;
    feeder_state_t     w_nxt_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_nxt_cnt;
    logic [SET_W-1:0]  r_set;
    logic [SET_W-1:0]  w_set_inc;
    logic              w_set_adv;
    logic              w_underrun;
    logic              w_start;

    logic [1:0]        r_layers;
    logic [NCNT_W-1:0] r_in;
    logic [NCNT_W-1:0] r_h1;
    logic [NCNT_W-1:0] r_h2;
    logic [NCNT_W-1:0] r_out;
    logic [1:0]        r_act;
    logic [WCNT_W-1:0] r_num_w;
    logic [CALC_W-1:0] r_calc;
    logic [SET_W-1:0]  r_sets;

    logic              r_we;
    logic              r_oe;
    logic              r_drv;
    logic [DW-1:0]     r_data;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_nxt_we;
    logic              w_nxt_oe;
    logic              w_nxt_drv;
    logic              w_nxt_ready;
    logic [DW-1:0]     w_nxt_data;

    logic [CNT_W-1:0]  w_wgt_last;
    logic [CNT_W-1:0]  w_inp_last;
    logic [CNT_W-1:0]  w_calc_last;
    logic [CNT_W-1:0]  w_out_last;

    assign w_start     = (r_state == ST_IDLE) && start;
    assign w_set_inc   = r_set + SET_W'(1);
    assign w_wgt_last  = CNT_W'(r_num_w) - C_ONE;
    assign w_inp_last  = CNT_W'(r_in);
    assign w_calc_last = CNT_W'(r_calc) - C_ONE;
    assign w_out_last  = CNT_W'(r_out);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt + C_ONE;
        w_set_adv   = 1'b0;
        w_underrun  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_nxt_cnt = '0;
                if (start) w_nxt_state = ST_LEAD;
            end
            ST_LEAD: if (r_cnt == C_LEAD_LAST) begin
                w_nxt_state = ST_CFG;
                w_nxt_cnt   = '0;
            end
            ST_CFG: if (r_cnt == C_CFG_LAST) begin
                w_nxt_state = ST_WGT;
                w_nxt_cnt   = '0;
            end
            ST_WGT: if (r_cnt == w_wgt_last) begin
                w_nxt_state = ST_INP;
                w_nxt_cnt   = '0;
            end
            ST_INP: if (r_cnt == w_inp_last) begin
                w_nxt_state = (r_calc == '0) ? ST_OUT : ST_CALC;
                w_nxt_cnt   = '0;
            end
            ST_CALC: if (r_cnt == w_calc_last) begin
                w_nxt_state = ST_OUT;
                w_nxt_cnt   = '0;
            end
            ST_OUT: if (r_cnt == w_out_last) begin
                w_set_adv   = 1'b1;
                w_nxt_state = (w_set_inc < r_sets) ? ST_LEAD : ST_FIN;
                w_nxt_cnt   = '0;
            end
            ST_FIN: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = '0;
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
        // An unserved handshake abandons the whole run; no retry of the frame
        if (r_ready && !src_valid) begin
            w_underrun  = 1'b1;
            w_nxt_state = ST_FIN;
            w_nxt_cnt   = '0;
        end
    end

    // Bus outputs are registered from the state being entered, so the word for
    // a cycle is already on the bus when that cycle begins.
    always_comb begin
        w_nxt_we    = (w_nxt_state == ST_LEAD) || (w_nxt_state == ST_CFG) ||
                      (w_nxt_state == ST_WGT)  || (w_nxt_state == ST_INP);
        w_nxt_drv   = (w_nxt_state == ST_CFG) || (w_nxt_state == ST_WGT) ||
                      (w_nxt_state == ST_INP);
        w_nxt_oe    = (w_nxt_state == ST_OUT);
        w_nxt_ready = ((w_nxt_state == ST_CFG) && (w_nxt_cnt == C_CFG_LAST)) ||
                      (w_nxt_state == ST_WGT) ||
                      ((w_nxt_state == ST_INP) && (w_nxt_cnt != w_inp_last));
        w_nxt_data  = '0;
        case (w_nxt_state)
            ST_CFG: begin
                case (w_nxt_cnt[2:0])
                    3'd0:    w_nxt_data = DW'(r_layers);
                    3'd1:    w_nxt_data = DW'(r_in);
                    3'd2:    w_nxt_data = DW'(r_h1);
                    3'd3:    w_nxt_data = DW'(r_h2);
                    3'd4:    w_nxt_data = DW'(r_out);
                    3'd5:    w_nxt_data = DW'(r_act);
                    default: w_nxt_data = '0;
                endcase
            end
            ST_WGT, ST_INP: w_nxt_data = src_data;
            default:        w_nxt_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_set    <= '0;
            r_we     <= 1'b0;
            r_oe     <= 1'b0;
            r_drv    <= 1'b0;
            r_data   <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_layers <= '0;
            r_in     <= '0;
            r_h1     <= '0;
            r_h2     <= '0;
            r_out    <= '0;
            r_act    <= '0;
            r_num_w  <= '0;
            r_calc   <= '0;
            r_sets   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_we    <= w_nxt_we;
            r_oe    <= w_nxt_oe;
            r_drv   <= w_nxt_drv;
            r_data  <= w_nxt_data;
            r_ready <= w_nxt_ready;
            r_busy  <= (w_nxt_state != ST_IDLE);
            r_done  <= (w_nxt_state == ST_FIN);
            if (w_start) begin
                r_layers <= cfg_num_layers;
                r_in     <= cfg_num_in;
                r_h1     <= cfg_num_h1;
                r_h2     <= cfg_num_h2;
                r_out    <= cfg_num_out;
                r_act    <= cfg_act;
                r_num_w  <= cfg_num_w;
                r_calc   <= cfg_calc_cycles;
                r_sets   <= cfg_num_sets;
                r_set    <= '0;
                r_err    <= 1'b0;
            end else begin
                if (w_underrun) r_err <= 1'b1;
                if (w_set_adv)  r_set <= w_set_inc;
            end
        end
    end

    npu_result_capture #(
        .DW     (DW),
        .NCNT_W (NCNT_W)
    ) u_capture (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_start),
        .i_oe        (r_oe),
        .i_num_out   (r_out),
        .i_data_in   (bus.npu_data_in),
        .o_res_data  (res_data),
        .o_res_valid (res_valid),
        .o_res_last  (res_last)
    );

    assign bus.npu_we       = r_we;
    assign bus.npu_oe       = r_oe;
    assign bus.npu_data_drv = r_drv;
    assign bus.npu_data_out = r_data;
    assign src_ready        = r_ready;
    assign busy             = r_busy;
    assign done             = r_done;
    assign err_underrun     = r_err;

    a_we_oe_exclusive: assert property (@(posedge clk) disable iff (rst) !(r_we && r_oe));
    a_drv_needs_we:    assert property (@(posedge clk) disable iff (rst) r_drv |-> r_we);

endmodule

// File: tb/tb_npu_host_feeder.sv
// Directed bench for npu_host_feeder: table of run configurations with
// hand-computed frame/result counts, plus reset and restart sequences.
module tb_npu_host_feeder;

    localparam int DW     = 32;
    localparam int WCNT_W = 12;
    localparam int NCNT_W = 5;
    localparam int SET_W  = 17;
    localparam int CALC_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [1:0]        cfg_num_layers;
    logic [NCNT_W-1:0] cfg_num_in;
    logic [NCNT_W-1:0] cfg_num_h1;
    logic [NCNT_W-1:0] cfg_num_h2;
    logic [NCNT_W-1:0] cfg_num_out;
    logic [1:0]        cfg_act;
    logic [WCNT_W-1:0] cfg_num_w;
    logic [CALC_W-1:0] cfg_calc_cycles;
    logic [SET_W-1:0]  cfg_num_sets;
    logic [DW-1:0]     src_data;
    logic              src_valid;
    logic              src_ready;
    logic [DW-1:0]     res_data;
    logic              res_valid;
    logic              res_last;
    logic              busy;
    logic              done;
    logic              err_underrun;

    always #5 clk = ~clk;

    npu_host_feeder_if #(.DW(DW)) bus_if ();

    npu_host_feeder #(
        .DW(DW), .WCNT_W(WCNT_W), .NCNT_W(NCNT_W), .SET_W(SET_W), .CALC_W(CALC_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_num_layers  (cfg_num_layers),
        .cfg_num_in      (cfg_num_in),
        .cfg_num_h1      (cfg_num_h1),
        .cfg_num_h2      (cfg_num_h2),
        .cfg_num_out     (cfg_num_out),
        .cfg_act         (cfg_act),
        .cfg_num_w       (cfg_num_w),
        .cfg_calc_cycles (cfg_calc_cycles),
        .cfg_num_sets    (cfg_num_sets),
        .src_data        (src_data),
        .src_valid       (src_valid),
        .src_ready       (src_ready),
        .bus             (bus_if.master),
        .res_data        (res_data),
        .res_valid       (res_valid),
        .res_last        (res_last),
        .busy            (busy),
        .done            (done),
        .err_underrun    (err_underrun)
    );

    typedef struct {
        int layers; int nin; int h1; int h2; int nout; int act;
        int nw; int calc; int sets; int drop; int restart;
        int e_we_len; int e_frames; int e_acc; int e_res; int e_last; int e_idle; int e_err;
    } vec_t;

    vec_t vecs[6];
    int   total = 0;
    int   bad   = 0;
    int   cur   = -1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL vec%0d %s: got %0h expected %0h", cur, name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] src_word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic set_cfg(input vec_t v);
        cfg_num_layers  = 2'(v.layers);
        cfg_num_in      = NCNT_W'(v.nin);
        cfg_num_h1      = NCNT_W'(v.h1);
        cfg_num_h2      = NCNT_W'(v.h2);
        cfg_num_out     = NCNT_W'(v.nout);
        cfg_act         = 2'(v.act);
        cfg_num_w       = WCNT_W'(v.nw);
        cfg_calc_cycles = CALC_W'(v.calc);
        cfg_num_sets    = SET_W'(v.sets);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    bus_if.npu_we, 0);
        check({tag, "_oe"},    bus_if.npu_oe, 0);
        check({tag, "_drv"},   bus_if.npu_data_drv, 0);
        check({tag, "_data"},  bus_if.npu_data_out, 0);
        check({tag, "_ready"}, src_ready, 0);
        check({tag, "_rval"},  res_valid, 0);
        check({tag, "_rlast"}, res_last, 0);
        check({tag, "_rdata"}, res_data, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_err"},   err_underrun, 0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [DW-1:0] acc_q[$];
        logic [DW-1:0] res_q[$];
        logic          last_q[$];
        int            tq[$];
        int            cfgw[7];
        int            src_idx, pos, frames, acc, nres, nlast, idle, nd, inv, gaps, oe_idx, cyc;
        logic          prev_we, prev_oe, hs, oe_now, done_seen, fin;
        logic [DW-1:0] exp_d;
        logic          exp_l;
        int            exp_t;

        cfgw = '{0, v.layers, v.nin, v.h1, v.h2, v.nout, v.act};
        src_idx = 0; pos = 0; frames = 0; acc = 0; nres = 0; nlast = 0; idle = 0;
        nd = 0; inv = 0; gaps = 0; oe_idx = 0; cyc = 0;
        prev_we = 1'b0; prev_oe = 1'b0; done_seen = 1'b0; fin = 1'b0;

        set_cfg(v);
        src_data  = src_word(0);
        src_valid = (v.drop != 0);
        bus_if.npu_data_in = 32'hA;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_clr", err_underrun, 0);
        check("busy_start", busy, 1);

        while (!fin && cyc < 4000) begin
            if (bus_if.npu_we && bus_if.npu_oe) inv++;
            if (bus_if.npu_data_drv && !bus_if.npu_we) inv++;
            if (bus_if.npu_we) begin
                if (!prev_we) pos = 0;
                if (pos == 0) begin
                    check("lead_drv", bus_if.npu_data_drv, 0);
                end else if (pos <= 6) begin
                    check("cfg_drv", bus_if.npu_data_drv, 1);
                    check("cfg_word", bus_if.npu_data_out, cfgw[pos]);
                end else begin
                    check("src_drv", bus_if.npu_data_drv, 1);
                    if (acc_q.size() == 0) check("src_word_avail", 0, 1);
                    else check("src_word", bus_if.npu_data_out, acc_q.pop_front());
                end
                pos++;
            end else if (prev_we) begin
                frames++;
                check("we_len", pos, v.e_we_len);
            end
            if (prev_oe && !bus_if.npu_oe && !bus_if.npu_we && !done) gaps++;
            if (busy && !bus_if.npu_we && !bus_if.npu_oe && !done) idle++;
            oe_now = bus_if.npu_oe;
            if (oe_now) begin
                res_q.push_back(bus_if.npu_data_in);
                last_q.push_back(oe_idx == v.nout);
                tq.push_back(cyc);
                oe_idx = (oe_idx == v.nout) ? 0 : oe_idx + 1;
            end
            if (res_valid) begin
                nres++;
                if (res_last) nlast++;
                if (res_q.size() == 0) begin
                    check("res_unexpected", 1, 0);
                end else begin
                    exp_d = res_q.pop_front();
                    exp_l = last_q.pop_front();
                    exp_t = tq.pop_front();
                    check("res_data", res_data, exp_d);
                    check("res_last", res_last, exp_l);
                    check("res_latency", cyc - exp_t, 1);
                end
            end
            if (done_seen) begin
                check("busy_after_done", busy, 0);
                check("done_width", done, 0);
                fin = 1'b1;
            end else if (done) begin
                nd++;
                check("err_at_done", err_underrun, v.e_err);
                done_seen = 1'b1;
            end
            if (v.restart != 0 && cyc == 5) begin
                start = 1'b1;
                cfg_num_sets = SET_W'(3);
                cfg_num_w    = WCNT_W'(2);
            end
            if (v.restart != 0 && cyc == 6) begin
                start = 1'b0;
                set_cfg(v);
            end
            hs = src_ready && src_valid;
            if (hs) begin
                acc++;
                acc_q.push_back(src_data);
            end
            prev_we = bus_if.npu_we;
            prev_oe = bus_if.npu_oe;
            @(posedge clk);
            #1;
            if (hs) begin
                src_idx++;
                src_data  = src_word(src_idx);
                src_valid = (src_idx != v.drop);
            end
            if (oe_now) bus_if.npu_data_in = bus_if.npu_data_in + 32'd1;
            @(negedge clk);
            cyc++;
        end

        check("completed", fin, 1);
        check("frames", frames, v.e_frames);
        check("accepts", acc, v.e_acc);
        check("res_count", nres, v.e_res);
        check("last_count", nlast, v.e_last);
        check("calc_idle", idle, v.e_idle);
        check("done_count", nd, 1);
        check("oe_we_gap", gaps, 0);
        check("invariant", inv, 0);
        check("res_pending", res_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{0, 9, 0, 0, 0, 0, 11, 5, 1, -1, 0,   28, 1, 21, 1, 1, 5, 0};
        vecs[1] = '{0, 9, 0, 0, 0, 0, 11, 5, 3, -1, 0,   28, 3, 63, 3, 3, 15, 0};
        vecs[2] = '{0, 9, 0, 0, 0, 0, 11, 5, 1, 4, 0,    11, 1, 4, 0, 0, 0, 1};
        vecs[3] = '{2, 1, 3, 4, 2, 1, 2, 0, 1, -1, 0,    11, 1, 4, 3, 1, 0, 0};
        vecs[4] = '{3, 0, 31, 7, 1, 3, 1, 2, 2, -1, 0,   9, 2, 4, 4, 2, 4, 0};
        vecs[5] = '{0, 9, 0, 0, 0, 0, 11, 5, 1, -1, 1,   28, 1, 21, 1, 1, 5, 0};

        rst = 1'b1;
        start = 1'b0;
        set_cfg(vecs[0]);
        src_data = '0;
        src_valid = 1'b0;
        bus_if.npu_data_in = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            cur = i;
            run_vec(vecs[i]);
        end

        // Asynchronous reset in the middle of the weight phase
        cur = 6;
        set_cfg(vecs[0]);
        src_data  = src_word(0);
        src_valid = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_we", bus_if.npu_we, 1);
        check("pre_rst_ready", src_ready, 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);

        cur = 7;
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/npu_host_feeder.md
Name: npu_host_feeder

Overview:
- Upstream host-side sequencer for the npu block's shared 32-bit word bus (we/oe/data).
- Per data set it drives the fixed load frame: a lead cycle, then 6 configuration words, then weights, then inputs. It then waits a programmed number of calculation cycles, asserts oe and captures the output neurons into a result stream.
- Repeats for cfg_num_sets data sets.
- Replaces the hand-timed stimulus used for benchmark runs (hotspot etc.) and is the synthesizable front end for the NPU.

Parameters:
- DW, 32, bus/data word width
- WCNT_W, 12, width of weight-count field (matches weight array index)
- NCNT_W, 5, width of neuron-count fields
- SET_W, 17, width of data-set counter (65536 sets must fit)
- CALC_W, 8, width of calculation-wait counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse in IDLE: latch cfg_* and begin run
- cfg_num_layers  in  2  config word 0
- cfg_num_in  in  NCNT_W  config word 1; input words per set = cfg_num_in+1
- cfg_num_h1  in  NCNT_W  config word 2
- cfg_num_h2  in  NCNT_W  config word 3
- cfg_num_out  in  NCNT_W  config word 4; output words per set = cfg_num_out+1
- cfg_act  in  2  config word 5
- cfg_num_w  in  WCNT_W  weight+bias words per set (>=1)
- cfg_calc_cycles  in  CALC_W  idle cycles between frame end and oe
- cfg_num_sets  in  SET_W  data sets per run (>=1)
- src_data  in  DW  weight/input word stream
- src_valid  in  1  stream word valid
- src_ready  out  1  feeder consumes src_data this cycle
- npu_we  out  1  NPU write enable
- npu_oe  out  1  NPU output enable
- npu_data_out  out  DW  word driven toward NPU
- npu_data_drv  out  1  tri-state enable for npu_data_out (top level forms the inout)
- npu_data_in  in  DW  bus value read back while npu_oe=1
- res_data  out  DW  captured output neuron
- res_valid  out  1  res_data valid (no backpressure)
- res_last  out  1  last output of a set
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run completion
- err_underrun  out  1  sticky: stream ran dry mid-frame; cleared by start or rst

Behaviour:
- Reset (async, rst=1): state IDLE.
  - All outputs are 0: npu_we, npu_oe, npu_data_drv, src_ready, res_*, busy, done, err_underrun, npu_data_out=0.
  - rst mid-run aborts immediately. The NPU bus is released in the same cycle.
- All outputs are registered. The state update is from edge k; the bus value for cycle k..k+1 is set at edge k.
- States: IDLE, LEAD, CFG, WGT, INP, CALC, OUT, FIN.
- IDLE: start=1 latches all cfg_*, clears err_underrun and the set counter, and goes to LEAD. start in any other state is ignored.
- LEAD (1 cycle): npu_we=1, npu_data_drv=0.
- CFG (6 cycles): npu_we=1, drv=1. Words in order are num_layers, num_in, num_h1, num_h2, num_out, act, each zero-extended to DW.
- WGT (cfg_num_w cycles) and INP (cfg_num_in+1 cycles): npu_we=1, drv=1, npu_data_out=src word.
  - src_ready=1 in exactly the cycle before each such bus cycle, i.e. the handshake edge loads npu_data_out.
  - Count = cfg_num_w + cfg_num_in + 1 accepts per set.
- Underrun: src_ready=1 and src_valid=0 sets err_underrun, deasserts we/drv at the next edge, and goes to FIN. The run is not continued. There is no partial retry.
- Frame length: npu_we is high for exactly 1+6+cfg_num_w+cfg_num_in+1 contiguous cycles.
- CALC: we=0, oe=0, drv=0 for cfg_calc_cycles cycles. 0 means OUT directly after INP.
- OUT (cfg_num_out+1 cycles): npu_oe=1, drv=0.
  - npu_data_in is sampled at the end of each oe cycle and presented on res_data with res_valid=1 one cycle later.
  - res_last accompanies the final output word of the set.
- After OUT: set counter+1. If it is below cfg_num_sets, go to LEAD immediately (oe falls and we rises on the same edge, no gap). Otherwise go to FIN.
- FIN: done=1 for one cycle, busy=0 next, then IDLE. The final res_valid may coincide with done.
- busy=1 in every state except IDLE.
- Invariants, checked by assertion:
  - npu_we and npu_oe are never both 1.
  - npu_data_drv=1 implies npu_we=1.
- Counters: a single word counter, WCNT_W+1 bits, is reused per phase and reloaded on each phase entry. The set counter is SET_W bits with no wrap (it terminates at cfg_num_sets).

Decomposition:
- Shared package npu_pkg holds:
  - the state encoding enum;
  - CFG_WORDS=6 and LEAD_CYCLES=1;
  - DW/NCNT_W/WCNT_W defaults, shared with npu.
- One sub-module npu_result_capture: oe-cycle sampling register, res_valid/res_last generation and a per-set output counter.

Test Plan:
- Protocol check:
  - Setup: layers=0, in=9, h1=h2=out=0, act=0, num_w=11, calc=5, sets=1, stream of 21 words always valid.
  - Required: we high for 1+6+11+10=28 cycles; CFG words 0,9,0,0,0,0; 5 idle cycles; oe for 1 cycle; one res_valid with res_last; done pulse.
- Multi-set: sets=3, same config.
  - Required: 3 back-to-back frames with no gap between oe fall and the next we rise; 63 src accepts; 3 res_last; done once.
- Underrun: drop src_valid at weight word 4.
  - Required: err_underrun=1; we/drv low next cycle; FIN then done; no res_valid.
  - Next start: clears err_underrun.
- Edge timing: calc=0, num_out=2 with npu_data_in stepping 0xA,0xB,0xC.
  - Required: oe directly follows the last input cycle; res_data A,B,C on consecutive cycles; last on C.
- Reset mid-run: rst asserted during WGT.
  - Required: same cycle, all outputs 0 and state IDLE; start ignored while busy in a separate run.
